if_stage: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Transmits to ID: drives IF_to_ID_bus {PC+4, inst} and IF_to_ID_valid under the valid/allow_in handshake.
- Receives from ID: consumes ID_to_PC_bus {target, taken} to redirect fetch after the delay slot.
- Owns the PC register and drives a synchronous instruction SRAM (1-cycle read latency); buffers the fetched word while ID stalls.

---
 rtl/if_stage_pkg.sv | 14 +
 rtl/if_stage.sv | 104 ++++++++++
 2 files changed

// File: rtl/if_stage_pkg.sv
// Shared widths and constants for the fetch stage and its neighbours.
package if_stage_pkg;

  localparam int unsigned IF_TO_ID_BUS_WD = 64;
  localparam int unsigned ID_TO_PC_BUS_WD = 33;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // Sequential successor of a word address; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction SRAM and hands
// {PC+4, inst} to ID under a valid/allow_in handshake. Taken branches redirect fetch after
// the delay slot; the fetched word is buffered while ID stalls.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ID_TO_PC_BUS_WD-1:0] ID_to_PC_bus,
  input  logic                       ID_allow_in,
  output logic                       IF_to_ID_valid,
  output logic [IF_TO_ID_BUS_WD-1:0] IF_to_ID_bus,
  output logic                       inst_sram_en,
  output logic [31:0]                inst_sram_addr,
  input  logic [31:0]                inst_sram_rdata
);

  logic        if_valid_q;
  logic [31:0] fetch_pc_q;
  logic        buf_valid_q;
  logic [31:0] inst_buf_q;
  logic        br_pending_q;
  logic [31:0] br_target_q;

  logic        br_taken;
  logic [31:0] br_target;
  logic        redirect_now;
  logic        if_allow_in;
  logic        fetch_en;
  logic [31:0] next_pc;
  logic [31:0] inst;

  assign br_taken  = ID_to_PC_bus[0];
  assign br_target = ID_to_PC_bus[32:1];

  // A taken branch only counts on the edge where it actually leaves ID.
  assign redirect_now = br_taken & ID_allow_in;
  assign if_allow_in  = ~if_valid_q | ID_allow_in;
  assign fetch_en     = ~reset & if_allow_in;

  // Next fetch address; a pending target from an earlier branch beats a new redirect.
  always_comb begin
    next_pc = pc_plus4(fetch_pc_q);
    if (br_pending_q) begin
      next_pc = br_target_q;
    end else if (redirect_now && if_valid_q) begin
      next_pc = br_target;
    end
  end

  // Buffered word takes over once the SRAM output is no longer guaranteed.
  always_comb begin
    inst = buf_valid_q ? inst_buf_q : inst_sram_rdata;
  end

  assign inst_sram_en   = fetch_en;
  assign inst_sram_addr = next_pc;
  assign IF_to_ID_valid = if_valid_q;
  assign IF_to_ID_bus   = {pc_plus4(fetch_pc_q), inst};

  // PC register and IF valid bit: advance on every issued fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid_q <= 1'b0;
      fetch_pc_q <= RESET_PC - 32'd4;
    end else if (fetch_en) begin
      if_valid_q <= 1'b1;
      fetch_pc_q <= next_pc;
    end else if (ID_allow_in) begin
      if_valid_q <= 1'b0;
    end
  end

  // Pending redirect: branch left ID before its delay slot was fetched.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_pending_q <= 1'b0;
      br_target_q  <= 32'h0;
    end else if (br_pending_q) begin
      if (fetch_en) begin
        br_pending_q <= 1'b0;
      end
    end else if (redirect_now && !if_valid_q) begin
      br_pending_q <= 1'b1;
      br_target_q  <= br_target;
    end
  end

  // Instruction buffer: capture the SRAM word on the first stalled cycle, release on handoff.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      inst_buf_q  <= 32'h0;
    end else if (if_valid_q && ID_allow_in) begin
      buf_valid_q <= 1'b0;
    end else if (if_valid_q && !ID_allow_in && !buf_valid_q) begin
      buf_valid_q <= 1'b1;
      inst_buf_q  <= inst_sram_rdata;
    end
  end

endmodule
